// File: rtl/ioctl_pkg.sv
// Shared types and constants for the ioctl download transmitter.
package ioctl_pkg;

  localparam int unsigned ADDR_W_DEF = 25;

  localparam logic [7:0] IDX_ROM   = 8'd0;
  localparam logic [7:0] IDX_NVRAM = 8'd4;
  localparam logic [7:0] IDX_DIP   = 8'd254;

  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StFetch,
    StStrobe,
    StGap,
    StTrail,
    StDone
  } ioctl_tx_state_t;

endpackage

// File: rtl/ioctl_stream_tx_pace.sv
// Loadable 8-bit down-counter with freeze; paces the LEAD, GAP and TRAIL phases.
module tx_pace_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       freeze,
  output logic [7:0] count,
  output logic       last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (!freeze && count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  // The phase ends in the cycle whose count is 1, so a load of N gives N cycles.
  assign last = (count == 8'd1);

endmodule

// File: rtl/ioctl_stream_tx.sv
// Host-side ioctl download driver: streams bytes from a valid/ready source
// into ioctl_wr/addr/dout strobes framed by ioctl_download.
module ioctl_stream_tx
  import ioctl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LEAD   = 4,
  parameter int unsigned GAP    = 3,
  parameter int unsigned TRAIL  = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        index,
  input  logic [ADDR_W-1:0] length,
  input  logic              src_valid,
  input  logic [7:0]        src_data,
  output logic              src_ready,
  input  logic              ioctl_wait,
  output logic              ioctl_download,
  output logic [7:0]        ioctl_index,
  output logic              ioctl_wr,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_dout,
  output logic              busy,
  output logic              done
);

  ioctl_tx_state_t   state_q, state_d;
  logic [ADDR_W-1:0] rem_q, addr_q;
  logic [7:0]        index_q, dout_q;
  logic              wr_q, download_q, busy_q, done_q;

  logic       pace_load, pace_freeze, pace_last;
  logic [7:0] pace_val, pace_count;
  logic       handshake;

  assign src_ready   = (state_q == StFetch) && !ioctl_wait;
  assign handshake   = src_ready && src_valid;
  assign pace_freeze = (state_q == StGap) && ioctl_wait;

  tx_pace_counter u_pace (
    .clk      (clk_sys),
    .rst_n    (reset_n),
    .load     (pace_load),
    .load_val (pace_val),
    .freeze   (pace_freeze),
    .count    (pace_count),
    .last     (pace_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StLead;
      StLead:   if (pace_last) state_d = (rem_q != '0) ? StFetch : StTrail;
      StFetch:  if (handshake) state_d = StStrobe;
      StStrobe: begin
        if (rem_q == ADDR_W'(1)) state_d = StTrail;
        else if (GAP == 0)       state_d = StFetch;
        else                     state_d = StGap;
      end
      StGap:    if (pace_last && !ioctl_wait) state_d = StFetch;
      StTrail:  if (pace_last) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Reload the pacer on entry to any timed phase.
  always_comb begin
    pace_load = 1'b0;
    pace_val  = 8'd0;
    if (state_d != state_q) begin
      case (state_d)
        StLead:  begin pace_load = 1'b1; pace_val = 8'(LEAD);  end
        StGap:   begin pace_load = 1'b1; pace_val = 8'(GAP);   end
        StTrail: begin pace_load = 1'b1; pace_val = 8'(TRAIL); end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      addr_q     <= '0;
      index_q    <= 8'd0;
      dout_q     <= 8'd0;
      wr_q       <= 1'b0;
      download_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        index_q <= index;
        rem_q   <= length;
        addr_q  <= '0;
      end
      if (handshake) dout_q <= src_data;
      if (state_q == StStrobe) begin
        addr_q <= addr_q + ADDR_W'(1);
        rem_q  <= rem_q - ADDR_W'(1);
      end
      wr_q       <= (state_d == StStrobe);
      download_q <= (state_d != StIdle) && (state_d != StDone);
      busy_q     <= (state_d != StIdle);
      done_q     <= (state_d == StDone);
    end
  end

  assign ioctl_download = download_q;
  assign ioctl_index    = index_q;
  assign ioctl_wr       = wr_q;
  assign ioctl_addr     = addr_q;
  assign ioctl_dout     = dout_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_ioctl_stream_tx.sv
// Self-checking bench: per-cycle wait/valid traces are fixed up front and an
// event-level model predicts strobe cycles, done cycle and envelope length.
module tb_ioctl_stream_tx;

  localparam int AW    = 25;
  localparam int LEAD  = 4;
  localparam int GAP   = 3;
  localparam int TRAIL = 4;
  localparam int MAXC  = 600;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    index = 8'd0;
  logic [AW-1:0] length = '0;
  logic          src_valid = 1'b0;
  logic [7:0]    src_data = 8'd0;
  logic          src_ready;
  logic          ioctl_wait = 1'b0;
  logic          ioctl_download, ioctl_wr, busy, done;
  logic [7:0]    ioctl_index, ioctl_dout;
  logic [AW-1:0] ioctl_addr;

  ioctl_stream_tx #(
    .ADDR_W (AW),
    .LEAD   (LEAD),
    .GAP    (GAP),
    .TRAIL  (TRAIL)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .start          (start),
    .index          (index),
    .length         (length),
    .src_valid      (src_valid),
    .src_data       (src_data),
    .src_ready      (src_ready),
    .ioctl_wait     (ioctl_wait),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;

  bit         wait_a  [MAXC];
  bit         valid_a [MAXC];
  bit         start_a [MAXC];
  logic [7:0] data_a  [64];

  int            obs_wr_cyc[$];
  int            obs_wr_addr[$];
  logic [7:0]    obs_wr_dout[$];
  int            obs_dl, obs_busy, obs_done_n, obs_done_cyc, obs_viol;
  logic [AW-1:0] obs_done_addr;
  logic [7:0]    obs_done_index;

  int exp_wr_cyc[$];
  int exp_done;

  task automatic clear_stim();
    for (int k = 0; k < MAXC; k++) begin
      wait_a[k]  = 1'b0;
      valid_a[k] = 1'b1;
      start_a[k] = 1'b0;
    end
    start_a[0] = 1'b1;
  endtask

  task automatic load_basic_data();
    data_a[0] = 8'hA5; data_a[1] = 8'h5A; data_a[2] = 8'h00; data_a[3] = 8'hFF;
  endtask

  // Cycle 0 carries the start pulse; LEAD occupies cycles 1..LEAD. Each byte is
  // taken at the first cycle with valid and no wait, strobed the next cycle,
  // then needs GAP wait-free cycles; the last byte is followed by TRAIL cycles.
  task automatic model(input int len);
    int c, g, n, f;
    exp_wr_cyc.delete();
    if (len == 0) begin
      exp_done = LEAD + TRAIL + 1;
      return;
    end
    f = LEAD + 1;
    for (int i = 0; i < len; i++) begin
      c = f;
      while (c < MAXC - 1 && !(valid_a[c] && !wait_a[c])) c++;
      exp_wr_cyc.push_back(c + 1);
      if (i == len - 1) begin
        exp_done = c + 2 + TRAIL;
      end else if (GAP == 0) begin
        f = c + 2;
      end else begin
        g = c + 2;
        n = 0;
        while (g < MAXC - 1) begin
          if (!wait_a[g]) n++;
          if (n == GAP) break;
          g++;
        end
        f = g + 1;
      end
    end
  endtask

  // Entered just after a rising edge with the DUT idle; records what it sees.
  task automatic run_transfer(input int len, input logic [7:0] idx, input logic [7:0] alt_idx,
                              input int ncyc);
    int src_idx;
    src_idx = 0;
    obs_wr_cyc.delete(); obs_wr_addr.delete(); obs_wr_dout.delete();
    obs_dl = 0; obs_busy = 0; obs_done_n = 0; obs_done_cyc = -1; obs_viol = 0;
    obs_done_addr = '0; obs_done_index = 8'd0;
    for (int cyc = 0; cyc < ncyc && cyc < MAXC; cyc++) begin
      start      = start_a[cyc];
      index      = (cyc == 0) ? idx : alt_idx;
      length     = (cyc == 0) ? AW'(len) : AW'(len + 7);
      src_valid  = valid_a[cyc];
      ioctl_wait = wait_a[cyc];
      src_data   = data_a[src_idx % 64];
      #1;
      if (ioctl_wr) begin
        obs_wr_cyc.push_back(cyc);
        obs_wr_addr.push_back(int'(ioctl_addr));
        obs_wr_dout.push_back(ioctl_dout);
      end
      if (ioctl_wr && !ioctl_download) obs_viol++;
      if (src_ready && ioctl_wait) obs_viol++;
      if (ioctl_download) obs_dl++;
      if (busy) obs_busy++;
      if (done) begin
        obs_done_n++;
        obs_done_cyc   = cyc;
        obs_done_addr  = ioctl_addr;
        obs_done_index = ioctl_index;
      end
      if (src_valid && src_ready) src_idx++;
      @(posedge clk_sys); #1;
    end
    start = 1'b0; src_valid = 1'b0; ioctl_wait = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    total++;
    if ({ioctl_download, ioctl_wr, busy, done, src_ready} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got %b want 00000",
               {ioctl_download, ioctl_wr, busy, done, src_ready});
    end
    total++;
    if ({ioctl_addr, ioctl_index, ioctl_dout} !== '0) begin
      bad++;
      $display("FAIL reset_regs got addr=%0d index=%0d dout=%0d want 0", ioctl_addr, ioctl_index,
               ioctl_dout);
    end
    reset_n = 1'b1;
    @(posedge clk_sys); #1;
  endtask

  task automatic test_basic();
    clear_stim(); load_basic_data(); model(4);
    run_transfer(4, 8'd0, 8'd0, exp_done + 3);
    total++;
    if (obs_wr_cyc.size() !== 4) begin
      bad++; $display("FAIL basic_wr_count got %0d want 4", obs_wr_cyc.size());
    end
    for (int i = 0; i < 4 && i < obs_wr_cyc.size(); i++) begin
      total++;
      if (obs_wr_cyc[i] !== exp_wr_cyc[i] || obs_wr_addr[i] !== i || obs_wr_dout[i] !== data_a[i]) begin
        bad++;
        $display("FAIL basic_byte%0d got cyc=%0d addr=%0d dout=%h want cyc=%0d addr=%0d dout=%h", i,
                 obs_wr_cyc[i], obs_wr_addr[i], obs_wr_dout[i], exp_wr_cyc[i], i, data_a[i]);
      end
    end
    total++;
    if (obs_dl !== exp_done - 1 || obs_busy !== exp_done) begin
      bad++;
      $display("FAIL basic_envelope got dl=%0d busy=%0d want dl=%0d busy=%0d", obs_dl, obs_busy,
               exp_done - 1, exp_done);
    end
    total++;
    if (obs_done_n !== 1 || obs_done_cyc !== exp_done || obs_done_addr !== AW'(4) || obs_viol !== 0) begin
      bad++;
      $display("FAIL basic_done got n=%0d cyc=%0d addr=%0d viol=%0d want n=1 cyc=%0d addr=4 viol=0",
               obs_done_n, obs_done_cyc, obs_done_addr, obs_viol, exp_done);
    end
  endtask

  task automatic test_zero_length();
    clear_stim(); model(0);
    run_transfer(0, 8'd254, 8'd0, exp_done + 3);
    total++;
    if (obs_wr_cyc.size() !== 0 || obs_dl !== LEAD + TRAIL) begin
      bad++;
      $display("FAIL zero_len got wr=%0d dl=%0d want wr=0 dl=%0d", obs_wr_cyc.size(), obs_dl,
               LEAD + TRAIL);
    end
    total++;
    if (obs_done_n !== 1 || obs_done_cyc !== exp_done || obs_done_index !== 8'd254 ||
        obs_done_addr !== '0) begin
      bad++;
      $display("FAIL zero_done got n=%0d cyc=%0d index=%0d addr=%0d want n=1 cyc=%0d index=254 addr=0",
               obs_done_n, obs_done_cyc, obs_done_index, obs_done_addr, exp_done);
    end
  endtask

  task automatic test_back_pressure();
    clear_stim(); load_basic_data();
    for (int k = 8; k < 18; k++) wait_a[k] = 1'b1;
    model(4);
    run_transfer(4, 8'd4, 8'd0, exp_done + 3);
    total++;
    if (obs_wr_cyc.size() !== 4 || obs_viol !== 0) begin
      bad++;
      $display("FAIL bp_count got wr=%0d viol=%0d want wr=4 viol=0", obs_wr_cyc.size(), obs_viol);
    end
    for (int i = 0; i < 4 && i < obs_wr_cyc.size(); i++) begin
      total++;
      if (obs_wr_cyc[i] !== exp_wr_cyc[i] || obs_wr_addr[i] !== i || obs_wr_dout[i] !== data_a[i]) begin
        bad++;
        $display("FAIL bp_byte%0d got cyc=%0d addr=%0d dout=%h want cyc=%0d addr=%0d dout=%h", i,
                 obs_wr_cyc[i], obs_wr_addr[i], obs_wr_dout[i], exp_wr_cyc[i], i, data_a[i]);
      end
    end
    total++;
    if (obs_done_cyc !== exp_done || obs_dl !== exp_done - 1) begin
      bad++;
      $display("FAIL bp_done got cyc=%0d dl=%0d want cyc=%0d dl=%0d", obs_done_cyc, obs_dl,
               exp_done, exp_done - 1);
    end
  endtask

  task automatic test_starvation();
    clear_stim(); load_basic_data();
    for (int k = 15; k < 35; k++) valid_a[k] = 1'b0;
    model(4);
    run_transfer(4, 8'd0, 8'd0, exp_done + 3);
    total++;
    if (obs_wr_cyc.size() !== 4) begin
      bad++; $display("FAIL starve_count got %0d want 4", obs_wr_cyc.size());
    end else begin
      total++;
      if (obs_wr_cyc[2] !== exp_wr_cyc[2] || obs_wr_addr[2] !== 2 || obs_wr_dout[2] !== 8'h00) begin
        bad++;
        $display("FAIL starve_byte2 got cyc=%0d addr=%0d dout=%h want cyc=%0d addr=2 dout=00",
                 obs_wr_cyc[2], obs_wr_addr[2], obs_wr_dout[2], exp_wr_cyc[2]);
      end
    end
    total++;
    if (obs_dl !== exp_done - 1 || obs_done_cyc !== exp_done) begin
      bad++;
      $display("FAIL starve_envelope got dl=%0d done=%0d want dl=%0d done=%0d", obs_dl,
               obs_done_cyc, exp_done - 1, exp_done);
    end
  endtask

  task automatic test_reset_mid();
    int src_idx;
    bit hit;
    int done_seen;
    src_idx = 0; hit = 1'b0; done_seen = 0;
    load_basic_data();
    for (int cyc = 0; cyc < 100; cyc++) begin
      start = (cyc == 0); index = 8'd9; length = AW'(4);
      src_valid = 1'b1; ioctl_wait = 1'b0; src_data = data_a[src_idx];
      #1;
      if (done) done_seen++;
      if (ioctl_wr && ioctl_addr == AW'(2)) begin
        hit = 1'b1;
        break;
      end
      if (src_valid && src_ready) src_idx++;
      @(posedge clk_sys); #1;
    end
    total++;
    if (!hit) begin
      bad++; $display("FAIL rst_mid_reach got no byte2 strobe want strobe within 100 cycles");
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({ioctl_wr, ioctl_download, busy, done} !== 4'b0 || ioctl_addr !== '0 || done_seen !== 0) begin
      bad++;
      $display("FAIL rst_mid_outputs got wr/dl/busy/done=%b addr=%0d done_seen=%0d want 0000 0 0",
               {ioctl_wr, ioctl_download, busy, done}, ioctl_addr, done_seen);
    end
    start = 1'b0; src_valid = 1'b0;
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    @(posedge clk_sys); #1;
    clear_stim(); model(4);
    run_transfer(4, 8'd4, 8'd0, exp_done + 3);
    total++;
    if (obs_wr_cyc.size() !== 4) begin
      bad++; $display("FAIL rst_mid_rerun_count got %0d want 4", obs_wr_cyc.size());
    end else begin
      total++;
      if (obs_wr_addr[0] !== 0 || obs_wr_dout[0] !== 8'hA5 || obs_wr_cyc[3] !== exp_wr_cyc[3]) begin
        bad++;
        $display("FAIL rst_mid_rerun got addr0=%0d dout0=%h cyc3=%0d want 0 a5 %0d", obs_wr_addr[0],
                 obs_wr_dout[0], obs_wr_cyc[3], exp_wr_cyc[3]);
      end
    end
  endtask

  task automatic test_ignored_start();
    clear_stim(); load_basic_data();
    start_a[9] = 1'b1; start_a[20] = 1'b1;
    model(4);
    run_transfer(4, 8'd4, 8'h33, exp_done + 3);
    total++;
    if (obs_done_index !== 8'd4 || obs_done_addr !== AW'(4) || obs_done_cyc !== exp_done) begin
      bad++;
      $display("FAIL ignore_start got index=%0d addr=%0d done=%0d want index=4 addr=4 done=%0d",
               obs_done_index, obs_done_addr, obs_done_cyc, exp_done);
    end
    total++;
    if (obs_wr_cyc.size() !== 4 || obs_dl !== exp_done - 1 || obs_done_n !== 1) begin
      bad++;
      $display("FAIL ignore_shape got wr=%0d dl=%0d done_n=%0d want wr=4 dl=%0d done_n=1",
               obs_wr_cyc.size(), obs_dl, obs_done_n, exp_done - 1);
    end
  endtask

  task automatic test_random();
    int len;
    logic [7:0] idx;
    for (int it = 0; it < 6; it++) begin
      clear_stim();
      len = $urandom_range(1, 12);
      idx = 8'($urandom_range(0, 255));
      for (int i = 0; i < 64; i++) data_a[i] = 8'($urandom_range(0, 255));
      for (int k = 1; k < 300; k++) begin
        wait_a[k]  = ($urandom_range(0, 4) == 0);
        valid_a[k] = ($urandom_range(0, 3) != 0);
      end
      model(len);
      run_transfer(len, idx, 8'd0, exp_done + 3);
      total++;
      if (obs_wr_cyc.size() !== len || obs_viol !== 0) begin
        bad++;
        $display("FAIL rand%0d_count got wr=%0d viol=%0d want wr=%0d viol=0", it, obs_wr_cyc.size(),
                 obs_viol, len);
      end
      for (int i = 0; i < len && i < obs_wr_cyc.size(); i++) begin
        total++;
        if (obs_wr_cyc[i] !== exp_wr_cyc[i] || obs_wr_addr[i] !== i || obs_wr_dout[i] !== data_a[i]) begin
          bad++;
          $display("FAIL rand%0d_byte%0d got cyc=%0d addr=%0d dout=%h want cyc=%0d addr=%0d dout=%h",
                   it, i, obs_wr_cyc[i], obs_wr_addr[i], obs_wr_dout[i], exp_wr_cyc[i], i, data_a[i]);
        end
      end
      total++;
      if (obs_done_cyc !== exp_done || obs_done_addr !== AW'(len) || obs_done_index !== idx ||
          obs_dl !== exp_done - 1) begin
        bad++;
        $display("FAIL rand%0d_done got cyc=%0d addr=%0d idx=%0d dl=%0d want %0d %0d %0d %0d", it,
                 obs_done_cyc, obs_done_addr, obs_done_index, obs_dl, exp_done, len, idx,
                 exp_done - 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_length();
    test_back_pressure();
    test_starvation();
    test_reset_mid();
    test_ignored_start();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
